// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences an external parallel-load / serial-shift register.
// A command loads a word, shifts it out for min(len, WIDTH) cycles in the
// requested direction, then pulses done. abort cancels an in-flight command.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             abort,
  input  logic             ser_in,
  output logic             sr_load,
  output logic             sr_shift,
  output logic             sr_dir,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_ser_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Length field saturates at the register width.
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;

  // State, remaining-shift counter and captured command registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      data_q  <= {WIDTH{1'b0}};
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic: accept in IDLE, abort wins over completion in LOAD/SHIFT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_LOAD;
          data_d  = cmd_data;
          dir_d   = cmd_dir;
          cnt_d   = (cmd_len > WIDTH_C) ? WIDTH_C : cmd_len;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - ONE_C;
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == ONE_C) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Strobes decode directly from the state register so reset clears them at once.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    sr_load   = (state_q == ST_LOAD);
    sr_shift  = (state_q == ST_SHIFT);
    ser_valid = (state_q == ST_SHIFT);
    done      = (state_q == ST_DONE);
    sr_dir    = dir_q;
    sr_data   = data_q;
    sr_ser_in = ser_in;
    if (state_q == ST_SHIFT) begin
      ser_out = dir_q ? sr_q[0] : sr_q[WIDTH-1];
    end else begin
      ser_out = 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: an attached shift-register model,
// a cycle-offset transaction model, directed cases and random traffic.
module tb_shift_seq_ctrl;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_data = '0;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_len = '0;
  logic          abort = 1'b0;
  logic          ser_in = 1'b0;
  logic          sr_load, sr_shift, sr_dir, sr_ser_in;
  logic [W-1:0]  sr_data;
  logic [W-1:0]  reg_q = '0;
  logic          ser_out, ser_valid, done, busy;

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_len(cmd_len), .abort(abort),
    .ser_in(ser_in), .sr_load(sr_load), .sr_shift(sr_shift), .sr_dir(sr_dir),
    .sr_data(sr_data), .sr_ser_in(sr_ser_in), .sr_q(reg_q), .ser_out(ser_out),
    .ser_valid(ser_valid), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // External 8-bit shift register driven by the controller's strobes.
  always @(posedge clk) begin
    if (sr_load) reg_q <= sr_data;
    else if (sr_shift) reg_q <= sr_dir ? {sr_ser_in, reg_q[W-1:1]} : {reg_q[W-2:0], sr_ser_in};
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Transaction model: offset of the current cycle from the accepting cycle.
  bit           m_busy = 1'b0;
  int           m_off  = 0;
  int           m_len  = 0;
  logic [W-1:0] m_data = '0;
  logic         m_dir  = 1'b0;

  // Monitor counters (written only by the compare process).
  int           mon_load = 0, mon_shift = 0, mon_done = 0;
  int           mon_acc_cyc = 0, mon_done_cyc = 0;
  logic [W-1:0] mon_bits = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every cycle, check all outputs against the model, then advance it.
  always @(negedge clk) begin : compare
    bit e_load, e_shift, e_done;
    int idx;
    if (!rst) begin
      m_busy = 1'b0; m_off = 0; m_len = 0; m_data = '0; m_dir = 1'b0;
    end
    e_load  = m_busy && (m_off == 1);
    e_shift = m_busy && (m_off >= 2) && (m_off <= 1 + m_len);
    e_done  = m_busy && (m_off == 2 + m_len);
    chk("cmd_ready", cmd_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("sr_load", sr_load, e_load);
    chk("sr_shift", sr_shift, e_shift);
    chk("ser_valid", ser_valid, e_shift);
    chk("done", done, e_done);
    chk("sr_dir", sr_dir, m_dir);
    chk("sr_ser_in", sr_ser_in, ser_in);
    if (e_load || !rst) chk("sr_data", sr_data, m_data);
    if (e_shift) begin
      idx = m_off - 2;
      chk("ser_out", ser_out, m_dir ? m_data[idx] : m_data[W-1-idx]);
    end
    if (sr_load) mon_load++;
    if (sr_shift) mon_shift++;
    if (ser_valid) mon_bits = {mon_bits[W-2:0], ser_out};
    if (done) begin mon_done++; mon_done_cyc = cyc; end
    if (cmd_valid && cmd_ready && rst) mon_acc_cyc = cyc;
    if (rst) begin
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1'b1; m_off = 1; m_data = cmd_data; m_dir = cmd_dir;
          m_len = (int'(cmd_len) > W) ? W : int'(cmd_len);
        end
      end else if ((e_load || e_shift) && abort) begin
        m_busy = 1'b0;
      end else if (e_done) begin
        m_busy = 1'b0;
      end else begin
        m_off++;
      end
    end
  end

  // Directed command from idle: pattern pat is fed on ser_in, MSB first, one bit per shift cycle.
  task automatic run_cmd(input string tag, input logic [W-1:0] d, input bit dir, input logic [CW-1:0] len,
                         input int abort_at, input logic [W-1:0] pat, input int exp_shifts,
                         input int exp_done, input int exp_lat, input logic [W-1:0] exp_bits);
    int s0, d0, l0, i;
    @(posedge clk); #1;
    s0 = mon_shift; d0 = mon_done; l0 = mon_load;
    cmd_valid = 1'b1; cmd_data = d; cmd_dir = dir; cmd_len = len; abort = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_data = W'($urandom);
    for (int k = 2; k <= 13; k++) begin
      @(posedge clk); #1;
      i = k - 2;
      ser_in = (i < W) ? pat[W-1-(i % W)] : 1'($urandom);
      abort  = (i == abort_at);
    end
    abort = 1'b0;
    chk({tag, " loads"}, mon_load - l0, 1);
    chk({tag, " shifts"}, mon_shift - s0, exp_shifts);
    chk({tag, " dones"}, mon_done - d0, exp_done);
    if (exp_done != 0) chk({tag, " done latency"}, mon_done_cyc - mon_acc_cyc, exp_lat);
    if (exp_shifts == W) chk({tag, " ser_out bits"}, mon_bits, exp_bits);
  endtask

  initial begin : stim
    int l0, d0;
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset sr_data", sr_data, 8'h00);
    @(posedge clk); #2 rst = 1'b1;

    run_cmd("A5 right", 8'hA5, 1'b1, 4'd8, -1, 8'h5A, 8, 1, 10, 8'hA5);
    run_cmd("A5 left",  8'hA5, 1'b0, 4'd8, -1, 8'h3C, 8, 1, 10, 8'hA5);
    chk("left final reg", reg_q, 8'h3C);
    run_cmd("len0",     8'h81, 1'b1, 4'd0, -1, 8'h00, 0, 1, 2, 8'h00);
    run_cmd("len15",    8'h6E, 1'b0, 4'd15, -1, 8'hF0, 8, 1, 10, 8'h6E);
    run_cmd("abort3",   8'hC3, 1'b1, 4'd8, 2, 8'h00, 3, 0, 0, 8'h00);
    run_cmd("abortlast",8'h17, 1'b0, 4'd3, 2, 8'h00, 3, 0, 0, 8'h00);

    // Asynchronous reset in the middle of a shift
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_data = 8'hFF; cmd_dir = 1'b1; cmd_len = 4'd8;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst sr_shift", sr_shift, 1'b0);
    chk("async rst ser_valid", ser_valid, 1'b0);
    chk("async rst sr_dir", sr_dir, 1'b0);
    chk("async rst sr_data", sr_data, 8'h00);
    chk("async rst cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #2 rst = 1'b1;
    run_cmd("after rst", 8'hA5, 1'b1, 4'd8, -1, 8'h99, 8, 1, 10, 8'hA5);

    // cmd_valid held high back-to-back with len=2: accepts every 5 cycles
    @(posedge clk); #1;
    l0 = mon_load; d0 = mon_done;
    cmd_valid = 1'b1; cmd_data = 8'h42; cmd_dir = 1'b0; cmd_len = 4'd2;
    repeat (20) @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    chk("b2b loads", mon_load - l0, 4);
    chk("b2b dones", mon_done - d0, 4);

    // Random traffic checked cycle by cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      cmd_valid = ($urandom % 3) != 0;
      cmd_data  = W'($urandom);
      cmd_dir   = 1'($urandom);
      cmd_len   = CW'($urandom_range(0, 15));
      abort     = ($urandom % 16) == 0;
      ser_in    = 1'($urandom);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; abort = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: shift register width, which is also the data width.
REQ-002 Parameter CNT_W, default 4: width of the length field and the bit counter (must hold WIDTH).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low (0 = reset).
REQ-005 Port cmd_valid, input, 1: a command is offered.
REQ-006 Port cmd_ready, output, 1: controller can accept a command.
REQ-007 Port cmd_data, input, WIDTH: parallel word to load.
REQ-008 Port cmd_dir, input, 1: 1 = shift right (LSB out first); 0 = shift left (MSB out first).
REQ-009 Port cmd_len, input, CNT_W: number of shift cycles requested.
REQ-010 Port abort, input, 1: cancels the command in flight.
REQ-011 Port ser_in, input, 1: serial line input, forwarded to the register.
REQ-012 Port sr_load, output, 1: load strobe to the 8-bit shift register.
REQ-013 Port sr_shift, output, 1: shift strobe to the register.
REQ-014 Port sr_dir, output, 1: direction to the register.
REQ-015 Port sr_data, output, WIDTH: parallel load word to the register.
REQ-016 Port sr_ser_in, output, 1: serial input to the register.
REQ-017 Port sr_q, input, WIDTH: current register contents.
REQ-018 Port ser_out, output, 1: bit being shifted out this cycle.
REQ-019 Port ser_valid, output, 1: ser_out is valid this cycle.
REQ-020 Port done, output, 1: one-cycle pulse on normal completion.
REQ-021 Port busy, output, 1: state is not IDLE.

Function
REQ-022 FSM states: IDLE, LOAD, SHIFT, DONE; the state register is updated only on clk edges and by reset.
REQ-023 cmd_ready = (state == IDLE), combinational; a command is accepted when cmd_valid && cmd_ready at a clk edge.
REQ-024 On acceptance: capture cmd_data, cmd_dir, and the effective length; next state LOAD.
- Effective length = min(cmd_len, WIDTH).
REQ-025 LOAD, one cycle: sr_load=1, sr_data=captured data; next state SHIFT if length>0, else DONE.
REQ-026 SHIFT: sr_shift=1 and ser_valid=1 every cycle; the counter decrements each cycle.
- Exactly "length" SHIFT cycles occur, then the next state is DONE.
REQ-027 ser_out in SHIFT = sr_q[0] when sr_dir=1, else sr_q[WIDTH-1]; combinational from sr_q.
REQ-028 DONE, one cycle: done=1; next state IDLE.
REQ-029 Latency for acceptance at edge N:
- LOAD occupies cycle N+1.
- SHIFT occupies cycles N+2 .. N+1+len.
- done is high in cycle N+2+len.
- cmd_ready is high again in cycle N+3+len.
REQ-030 sr_dir holds the captured direction from LOAD through DONE; it holds its last value in IDLE.
REQ-031 sr_ser_in = ser_in, combinational, in all states.
REQ-032 sr_load, sr_shift, ser_valid and done are mutually exclusive and are 0 in IDLE.
REQ-033 abort=1 in LOAD or SHIFT: next state IDLE, no done pulse, no further strobes after that edge.
REQ-034 abort has no effect in IDLE or DONE.
REQ-035 abort in the same cycle as the last SHIFT cycle: abort wins, next state IDLE, no done.
REQ-036 cmd_valid while busy is ignored and not queued; the command is accepted only once cmd_ready=1.

Reset
REQ-037 rst=0 asynchronously forces: state IDLE; counter 0; captured data and direction 0.
- sr_load, sr_shift, sr_dir, sr_data, ser_valid, done all 0.
REQ-038 Reset mid-command discards the command with no done pulse; cmd_ready=1 on the first cycle after rst returns to 1.

Verification
REQ-039 cmd_data=8'hA5, dir=1, len=8, with the register model attached -> 1 LOAD, 8 SHIFT cycles, ser_out 1,0,1,0,0,1,0,1, done in cycle 10 after accept.
REQ-040 cmd_data=8'hA5, dir=0, len=8 -> ser_out 1,0,1,0,0,1,0,1 (MSB first), register ends with ser_in bits shifted in.
REQ-041 len=0 -> LOAD then DONE, zero SHIFT cycles; len=15 -> exactly 8 SHIFT cycles.
REQ-042 abort asserted in the 3rd SHIFT cycle of len=8 -> exactly 3 shift strobes, no done, cmd_ready=1 next cycle.
REQ-043 rst driven low mid-SHIFT between clock edges -> all strobes 0 immediately; after release, a new command completes normally.
REQ-044 cmd_valid held high back-to-back -> second command accepted only in the IDLE cycle following done; no lost or duplicated LOAD.
